// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline: writeback select, PC source and
// memory-stage FSM encodings, plus the default datapath widths.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_BEQ  = 2'd1,
      PC_BNE  = 2'd2,
      PC_JUMP = 2'd3
   } pc_src_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_HALTED  = 2'd2
   } st_t;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline latch. A flush inserts a bubble by dropping the write
// enable; the data fields keep their last retired values.
module mem_wb #(
   parameter int WORD_W = cpu_types_pkg::WORD_W,
   parameter int REG_AW = cpu_types_pkg::REG_AW
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              en,
   input  logic              flush,
   input  logic              regwr,
   input  logic [REG_AW-1:0] wsel,
   input  logic [WORD_W-1:0] wdat,
   output logic              wb_regwr,
   output logic [REG_AW-1:0] wb_wsel,
   output logic [WORD_W-1:0] wb_wdat
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the clock edge.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_regwr <= 1'b0;
         wb_wsel  <= '0;
         wb_wdat  <= '0;
      end else if (flush) begin
         wb_regwr <= 1'b0;
      end else if (en) begin
         wb_regwr <= regwr;
         wb_wsel  <= wsel;
         wb_wdat  <= wdat;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage: dcache handshake FSM, branch/jump redirect, writeback select
// and the MEM/WB latch, with a sticky halt once a halt instruction retires.
module mem_wb_stage #(
   parameter int WORD_W = cpu_types_pkg::WORD_W,
   parameter int REG_AW = cpu_types_pkg::REG_AW
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] alu_i,
   input  logic [WORD_W-1:0] rdat2_i,
   input  logic [WORD_W-1:0] imm_i,
   input  logic [WORD_W-1:0] pc4_i,
   input  logic [WORD_W-1:0] jaddr_i,
   input  logic [WORD_W-1:0] braddr_i,
   input  logic [REG_AW-1:0] wsel_i,
   input  logic              regwr_i,
   input  logic              dren_i,
   input  logic              dwen_i,
   input  logic              halt_i,
   input  logic              zero_i,
   input  logic [1:0]        memtoreg_i,
   input  logic [1:0]        pcsrc_i,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              stall_o,
   output logic              redirect_o,
   output logic [WORD_W-1:0] target_o,
   output logic              wb_regwr_o,
   output logic [REG_AW-1:0] wb_wsel_o,
   output logic [WORD_W-1:0] wb_wdat_o,
   output logic              halt_o
);

   import cpu_types_pkg::*;

   st_t               state, state_n;
   logic              active;
   logic              mem_op;
   logic              retire;
   logic              taken;
   logic [WORD_W-1:0] br_tgt;
   logic [WORD_W-1:0] wdat;

   // Requests are gated by nRST so an in-flight access drops the moment reset asserts.
   assign active    = nRST && (state != ST_HALTED);
   assign mem_op    = dren_i || dwen_i;
   assign dmemREN   = active && dren_i;
   assign dmemWEN   = active && dwen_i && !dren_i;
   assign dmemaddr  = alu_i;
   assign dmemstore = rdat2_i;
   assign stall_o   = active && mem_op && !dhit;
   assign retire    = active && !stall_o;

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      state_n = state;
      case (state)
         ST_IDLE, ST_ACCESS: begin
            if (retire && halt_i) state_n = ST_HALTED;
            else if (stall_o)     state_n = ST_ACCESS;
            else                  state_n = ST_IDLE;
         end
         ST_HALTED: state_n = ST_HALTED;
         default:   state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= ST_IDLE;
      else       state <= state_n;
   end

   assign halt_o = (state == ST_HALTED);

   always_comb begin
      taken  = 1'b0;
      br_tgt = braddr_i;
      case (pc_src_t'(pcsrc_i))
         PC_BEQ:  taken = zero_i;
         PC_BNE:  taken = !zero_i;
         PC_JUMP: begin
            taken  = 1'b1;
            br_tgt = jaddr_i;
         end
         default: taken = 1'b0;
      endcase
   end

   // Only a retiring instruction may flush upstream, so a stalled branch cannot fire twice.
   assign redirect_o = retire && taken;
   assign target_o   = redirect_o ? br_tgt : '0;

   always_comb begin
      wdat = alu_i;
      case (wb_sel_t'(memtoreg_i))
         WB_ALU:  wdat = alu_i;
         WB_LOAD: wdat = dload;
         WB_PC4:  wdat = pc4_i;
         WB_IMM:  wdat = imm_i;
         default: wdat = alu_i;
      endcase
   end

   mem_wb #(
      .WORD_W (WORD_W),
      .REG_AW (REG_AW)
   ) u_mem_wb (
      .CLK      (CLK),
      .nRST     (nRST),
      .en       (retire),
      .flush    (!retire),
      .regwr    (regwr_i && (wsel_i != '0)),
      .wsel     (wsel_i),
      .wdat     (wdat),
      .wb_regwr (wb_regwr_o),
      .wb_wsel  (wb_wsel_o),
      .wb_wdat  (wb_wdat_o)
   );

   a_req_excl: assert property (@(posedge CLK) disable iff (!nRST) !(dren_i && dwen_i))
      else $error("dren_i and dwen_i asserted together");

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a table of single-cycle retire vectors plus
// hand-written sequences for stalled loads, reset mid-access and halt.
module tb_mem_wb_stage;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] alu_i, rdat2_i, imm_i, pc4_i, jaddr_i, braddr_i, dload;
   logic [4:0]  wsel_i;
   logic        regwr_i, dren_i, dwen_i, halt_i, zero_i, dhit;
   logic [1:0]  memtoreg_i, pcsrc_i;
   logic        dmemREN, dmemWEN, stall_o, redirect_o, wb_regwr_o, halt_o;
   logic [31:0] dmemaddr, dmemstore, target_o, wb_wdat_o;
   logic [4:0]  wb_wsel_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   mem_wb_stage dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .alu_i      (alu_i),
      .rdat2_i    (rdat2_i),
      .imm_i      (imm_i),
      .pc4_i      (pc4_i),
      .jaddr_i    (jaddr_i),
      .braddr_i   (braddr_i),
      .wsel_i     (wsel_i),
      .regwr_i    (regwr_i),
      .dren_i     (dren_i),
      .dwen_i     (dwen_i),
      .halt_i     (halt_i),
      .zero_i     (zero_i),
      .memtoreg_i (memtoreg_i),
      .pcsrc_i    (pcsrc_i),
      .dhit       (dhit),
      .dload      (dload),
      .dmemREN    (dmemREN),
      .dmemWEN    (dmemWEN),
      .dmemaddr   (dmemaddr),
      .dmemstore  (dmemstore),
      .stall_o    (stall_o),
      .redirect_o (redirect_o),
      .target_o   (target_o),
      .wb_regwr_o (wb_regwr_o),
      .wb_wsel_o  (wb_wsel_o),
      .wb_wdat_o  (wb_wdat_o),
      .halt_o     (halt_o)
   );

   typedef struct {
      string       name;
      logic [31:0] alu, rdat2, imm, pc4, jaddr, braddr;
      logic [4:0]  wsel;
      logic        regwr, dren, dwen, zero, dhit;
      logic [1:0]  memtoreg, pcsrc;
      logic [31:0] dload;
      logic        e_ren, e_wen, e_stall, e_redir;
      logic [31:0] e_target;
      logic        e_regwr;
      logic [4:0]  e_wsel;
      logic [31:0] e_wdat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      alu_i = '0; rdat2_i = '0; imm_i = '0; pc4_i = '0; jaddr_i = '0; braddr_i = '0;
      dload = '0; wsel_i = '0; regwr_i = F; dren_i = F; dwen_i = F; halt_i = F;
      zero_i = F; dhit = F; memtoreg_i = 2'd0; pcsrc_i = 2'd0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = F;
      idle_inputs();
      #1;
      check("rst_halt", {31'd0, halt_o}, 32'd0);
      check("rst_wb_regwr", {31'd0, wb_regwr_o}, 32'd0);
      @(negedge CLK);
      nRST = T;
      step();
   endtask

   initial begin
      // Field order: name, alu, rdat2, imm, pc4, jaddr, braddr, wsel, regwr, dren, dwen,
      // zero, dhit, memtoreg, pcsrc, dload | ren, wen, stall, redir, target, regwr, wsel, wdat
      vecs[0]  = '{"alu",    32'h1234, '0, '0, '0, '0, '0, 5'd5, T, F, F, F, F, 2'd0, 2'd0, '0,
                   F, F, F, F, '0, T, 5'd5, 32'h1234};
      vecs[1]  = '{"pc4",    32'h9999, '0, '0, 32'h104, '0, '0, 5'd31, T, F, F, F, F, 2'd2, 2'd0, '0,
                   F, F, F, F, '0, T, 5'd31, 32'h104};
      vecs[2]  = '{"imm",    32'h1, '0, 32'hABCD0000, '0, '0, '0, 5'd3, T, F, F, F, F, 2'd3, 2'd0, '0,
                   F, F, F, F, '0, T, 5'd3, 32'hABCD0000};
      vecs[3]  = '{"store",  32'h200, 32'h55, '0, '0, '0, '0, 5'd0, F, F, T, F, T, 2'd0, 2'd0, '0,
                   F, T, F, F, '0, F, 5'd0, 32'h200};
      vecs[4]  = '{"beq_t",  '0, '0, '0, '0, 32'h80, 32'h40, 5'd0, F, F, F, T, F, 2'd0, 2'd1, '0,
                   F, F, F, T, 32'h40, F, 5'd0, 32'h0};
      vecs[5]  = '{"bne_nt", '0, '0, '0, '0, 32'h80, 32'h40, 5'd0, F, F, F, T, F, 2'd0, 2'd2, '0,
                   F, F, F, F, '0, F, 5'd0, 32'h0};
      vecs[6]  = '{"bne_t",  '0, '0, '0, '0, 32'h80, 32'h44, 5'd0, F, F, F, F, F, 2'd0, 2'd2, '0,
                   F, F, F, T, 32'h44, F, 5'd0, 32'h0};
      vecs[7]  = '{"beq_nt", '0, '0, '0, '0, 32'h80, 32'h48, 5'd0, F, F, F, F, F, 2'd0, 2'd1, '0,
                   F, F, F, F, '0, F, 5'd0, 32'h0};
      vecs[8]  = '{"jump",   '0, '0, '0, 32'h10, 32'h80, 32'h40, 5'd31, T, F, F, F, F, 2'd2, 2'd3, '0,
                   F, F, F, T, 32'h80, T, 5'd31, 32'h10};
      vecs[9]  = '{"wsel0",  32'h77, '0, '0, '0, '0, '0, 5'd0, T, F, F, F, F, 2'd0, 2'd0, '0,
                   F, F, F, F, '0, F, 5'd0, 32'h77};
      vecs[10] = '{"load0",  32'h300, '0, '0, '0, '0, '0, 5'd7, T, T, F, F, T, 2'd1, 2'd0, 32'h11223344,
                   T, F, F, F, '0, T, 5'd7, 32'h11223344};

      idle_inputs();
      nRST = F;
      #12;
      check("reset_ren", {31'd0, dmemREN}, 32'd0);
      check("reset_wb_wdat", wb_wdat_o, 32'd0);
      check("reset_halt", {31'd0, halt_o}, 32'd0);
      @(negedge CLK);
      nRST = T;
      step();

      // Single-cycle retire vectors
      foreach (vecs[i]) begin
         alu_i = vecs[i].alu; rdat2_i = vecs[i].rdat2; imm_i = vecs[i].imm; pc4_i = vecs[i].pc4;
         jaddr_i = vecs[i].jaddr; braddr_i = vecs[i].braddr; wsel_i = vecs[i].wsel;
         regwr_i = vecs[i].regwr; dren_i = vecs[i].dren; dwen_i = vecs[i].dwen;
         zero_i = vecs[i].zero; dhit = vecs[i].dhit; memtoreg_i = vecs[i].memtoreg;
         pcsrc_i = vecs[i].pcsrc; dload = vecs[i].dload; halt_i = F;
         #2;
         check({vecs[i].name, "_ren"},    {31'd0, dmemREN},    {31'd0, vecs[i].e_ren});
         check({vecs[i].name, "_wen"},    {31'd0, dmemWEN},    {31'd0, vecs[i].e_wen});
         check({vecs[i].name, "_stall"},  {31'd0, stall_o},    {31'd0, vecs[i].e_stall});
         check({vecs[i].name, "_redir"},  {31'd0, redirect_o}, {31'd0, vecs[i].e_redir});
         check({vecs[i].name, "_target"}, target_o,            vecs[i].e_target);
         check({vecs[i].name, "_addr"},   dmemaddr,            vecs[i].alu);
         check({vecs[i].name, "_store"},  dmemstore,           vecs[i].rdat2);
         step();
         check({vecs[i].name, "_wb_regwr"}, {31'd0, wb_regwr_o}, {31'd0, vecs[i].e_regwr});
         check({vecs[i].name, "_wb_wsel"},  {27'd0, wb_wsel_o},  {27'd0, vecs[i].e_wsel});
         check({vecs[i].name, "_wb_wdat"},  wb_wdat_o,           vecs[i].e_wdat);
      end

      // Load that hits after three wait cycles; a jump riding with it must not redirect early
      idle_inputs();
      alu_i = 32'h100; dren_i = T; memtoreg_i = 2'd1; wsel_i = 5'd8; regwr_i = T;
      pcsrc_i = 2'd3; jaddr_i = 32'h300; dload = 32'hBAD0BAD0;
      for (int c = 0; c < 3; c++) begin
         #2;
         check($sformatf("ld_stall_c%0d", c), {31'd0, stall_o}, 32'd1);
         check($sformatf("ld_ren_c%0d", c), {31'd0, dmemREN}, 32'd1);
         check($sformatf("ld_redir_c%0d", c), {31'd0, redirect_o}, 32'd0);
         step();
         check($sformatf("ld_bubble_c%0d", c), {31'd0, wb_regwr_o}, 32'd0);
      end
      dhit = T; dload = 32'hDEADBEEF;
      #2;
      check("ld_hit_stall", {31'd0, stall_o}, 32'd0);
      check("ld_hit_ren", {31'd0, dmemREN}, 32'd1);
      check("ld_hit_redir", {31'd0, redirect_o}, 32'd1);
      check("ld_hit_target", target_o, 32'h300);
      step();
      check("ld_wb_regwr", {31'd0, wb_regwr_o}, 32'd1);
      check("ld_wb_wsel", {27'd0, wb_wsel_o}, 32'd8);
      check("ld_wb_wdat", wb_wdat_o, 32'hDEADBEEF);
      idle_inputs();
      #2;
      check("ld_done_ren", {31'd0, dmemREN}, 32'd0);

      // Reset while a store is waiting in ACCESS
      step();
      alu_i = 32'hCAFE; wsel_i = 5'd4; regwr_i = T;
      step();
      check("pre_rst_wdat", wb_wdat_o, 32'hCAFE);
      idle_inputs();
      alu_i = 32'h400; rdat2_i = 32'h99; dwen_i = T;
      #2;
      check("st_wait_stall", {31'd0, stall_o}, 32'd1);
      step();
      #2;
      check("st_access_wen", {31'd0, dmemWEN}, 32'd1);
      nRST = F;
      #1;
      check("mid_rst_wen", {31'd0, dmemWEN}, 32'd0);
      check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
      check("mid_rst_wb_regwr", {31'd0, wb_regwr_o}, 32'd0);
      check("mid_rst_wb_wsel", {27'd0, wb_wsel_o}, 32'd0);
      check("mid_rst_wb_wdat", wb_wdat_o, 32'd0);
      check("mid_rst_halt", {31'd0, halt_o}, 32'd0);
      idle_inputs();
      @(negedge CLK);
      nRST = T;
      step();
      alu_i = 32'h5A; wsel_i = 5'd9; regwr_i = T;
      #2;
      check("post_rst_stall", {31'd0, stall_o}, 32'd0);
      step();
      check("post_rst_wb_wdat", wb_wdat_o, 32'h5A);

      // Halt with a write to r0, then sticky halt blocks everything
      idle_inputs();
      halt_i = T; regwr_i = T; wsel_i = 5'd0; alu_i = 32'h9;
      #2;
      check("halt_stall", {31'd0, stall_o}, 32'd0);
      step();
      check("halt_set", {31'd0, halt_o}, 32'd1);
      check("halt_wb_regwr", {31'd0, wb_regwr_o}, 32'd0);
      idle_inputs();
      dren_i = T; alu_i = 32'h500; pcsrc_i = 2'd3; jaddr_i = 32'h600; regwr_i = T; wsel_i = 5'd6;
      #2;
      check("halted_ren", {31'd0, dmemREN}, 32'd0);
      check("halted_stall", {31'd0, stall_o}, 32'd0);
      check("halted_redir", {31'd0, redirect_o}, 32'd0);
      check("halted_target", target_o, 32'd0);
      step();
      step();
      check("halt_sticky", {31'd0, halt_o}, 32'd1);
      check("halted_wb_regwr", {31'd0, wb_regwr_o}, 32'd0);
      do_reset();

      // Halt riding on a load: access completes before halting
      alu_i = 32'h600; dren_i = T; halt_i = T; regwr_i = T; wsel_i = 5'd2; memtoreg_i = 2'd1;
      #2;
      check("hl_stall", {31'd0, stall_o}, 32'd1);
      step();
      check("hl_not_halted", {31'd0, halt_o}, 32'd0);
      dhit = T; dload = 32'h77;
      #2;
      check("hl_hit_stall", {31'd0, stall_o}, 32'd0);
      step();
      check("hl_halted", {31'd0, halt_o}, 32'd1);
      check("hl_wb_regwr", {31'd0, wb_regwr_o}, 32'd1);
      check("hl_wb_wdat", wb_wdat_o, 32'h77);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
